// File: rtl/shift_register_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_ctrl_pkg
//   Shared definitions for the shift-register command sequencer:
//     - state_t          : FSM state encoding (IDLE, LOAD, SHIFT, CAPT, RESP)
//     - len_width()      : width of the shift-count field, $clog2(BW_DATA+1)
//     - TIMEOUT_CYC_DEFAULT : default SHIFT stall limit (timeout build only)
// -----------------------------------------------------------------------------
package shift_register_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 16;

    // A count field must be able to represent 0..bw inclusive.
    function automatic int unsigned len_width(input int unsigned bw);
        return $clog2(bw + 1);
    endfunction

endpackage

// File: rtl/shift_register_ctrl_stall_cnt.sv
// -----------------------------------------------------------------------------
// sr_stall_cnt
//   Counts consecutive stalled SHIFT cycles for the sequencer timeout.
//   Only instantiated when SR_CTRL_TIMEOUT_EN is defined.
//
//   Ports:
//     clk   in   clock
//     rst   in   synchronous active-high reset
//     clear in   restart the count (bit accepted or not in SHIFT)
//     inc   in   one more stalled cycle
//     count out  stalled cycles seen so far
//     term  out  high during the LIMIT-th consecutive stalled cycle
// -----------------------------------------------------------------------------
module sr_stall_cnt #(
    parameter  int unsigned LIMIT = 16,
    localparam int unsigned SW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [SW-1:0] count,
    output logic          term
);

    // term is combinational so the FSM leaves SHIFT on the edge that ends
    // the LIMIT-th stalled cycle; the value LIMIT itself is never stored.
    assign term = inc && (count == SW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= term ? '0 : count + SW'(1);
        end
    end

endmodule

// File: rtl/shift_register_ctrl.sv
// -----------------------------------------------------------------------------
// shift_register_ctrl
//   Command-driven sequencer for a parallel-load / serial-shift register.
//   Accepts {word, shift count} on a valid/ready command port, loads the word
//   into the register, gates exactly N shift cycles fed from a valid/ready
//   serial bit stream, captures the register and returns it on a valid/ready
//   result port.
//
//   Build option: define SR_CTRL_TIMEOUT_EN to abandon SHIFT after TIMEOUT_CYC
//   consecutive cycles without a serial bit; the result is then flagged with
//   o_res_err. Without it, SHIFT waits forever and o_res_err stays 0.
//
//   Ports:
//     i_clk, i_rst                 clock, synchronous active-high reset
//     i_cmd_valid/o_cmd_ready      command handshake (ready only in IDLE)
//     i_cmd_data, i_cmd_len        word to load, shift count (clamped)
//     i_sin_valid/o_sin_ready      serial bit handshake (ready only in SHIFT)
//     i_sin_bit                    serial bit
//     o_sr_load, o_sr_en           shift register parallel load / shift enable
//     o_sr_d, o_sr_s               shift register parallel data / serial in
//     i_sr_q                       shift register contents
//     o_res_valid/i_res_ready      result handshake
//     o_res_data, o_res_err        captured word, timeout flag
// -----------------------------------------------------------------------------
module shift_register_ctrl
    import shift_register_ctrl_pkg::*;
#(
    parameter  int unsigned BW_DATA     = 8,
    parameter  int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    localparam int unsigned CW          = len_width(BW_DATA)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [BW_DATA-1:0] i_cmd_data,
    input  logic [CW-1:0]      i_cmd_len,
    input  logic               i_sin_valid,
    output logic               o_sin_ready,
    input  logic               i_sin_bit,
    output logic               o_sr_load,
    output logic               o_sr_en,
    output logic [BW_DATA-1:0] o_sr_d,
    output logic               o_sr_s,
    input  logic [BW_DATA-1:0] i_sr_q,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [BW_DATA-1:0] o_res_data,
    output logic               o_res_err
);

    state_t             state;
    state_t             state_next;

    logic [CW-1:0]      count;
    logic [CW-1:0]      len_clamped;
    logic [BW_DATA-1:0] data;
    logic [BW_DATA-1:0] res_data;
    logic               res_err;

    logic               cmd_fire;
    logic               sin_fire;
    logic               last_bit;
    logic               stall_term;

    assign cmd_fire = (state == ST_IDLE)  && i_cmd_valid;
    assign sin_fire = (state == ST_SHIFT) && i_sin_valid;
    // count is never 0 in SHIFT, so reaching 1 on an accept means done.
    assign last_bit = sin_fire && (count == CW'(1));

    assign len_clamped = (i_cmd_len > CW'(BW_DATA)) ? CW'(BW_DATA) : i_cmd_len;

    // -------------------------------------------------------------------------
    // Stall timeout
    // -------------------------------------------------------------------------
`ifdef SR_CTRL_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT_CYC + 1);

    logic          stall_clear;
    logic          stall_inc;
    logic [SW-1:0] stall_count_unused;

    assign stall_inc   = (state == ST_SHIFT) && !i_sin_valid;
    assign stall_clear = !stall_inc;

    sr_stall_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_stall_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (stall_clear),
        .inc   (stall_inc),
        .count (stall_count_unused),
        .term  (stall_term)
    );
`else
    logic [31:0] timeout_cyc_unused;

    assign timeout_cyc_unused = TIMEOUT_CYC;
    assign stall_term         = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (i_cmd_valid) state_next = ST_LOAD;
            ST_LOAD:  state_next = (count != '0) ? ST_SHIFT : ST_CAPT;
            ST_SHIFT: if (last_bit || stall_term) state_next = ST_CAPT;
            ST_CAPT:  state_next = ST_RESP;
            ST_RESP:  if (i_res_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_cmd_ready = 1'b0;
        o_sin_ready = 1'b0;
        o_sr_load   = 1'b0;
        o_sr_en     = 1'b0;
        o_sr_s      = 1'b0;
        o_res_valid = 1'b0;
        unique case (state)
            ST_IDLE:  o_cmd_ready = 1'b1;
            ST_LOAD:  o_sr_load   = 1'b1;
            ST_SHIFT: begin
                o_sin_ready = 1'b1;
                o_sr_en     = i_sin_valid;
                o_sr_s      = i_sin_bit;
            end
            ST_CAPT:  ;
            ST_RESP:  o_res_valid = 1'b1;
            default:  ;
        endcase
    end

    assign o_sr_d     = data;
    assign o_res_data = res_data;
    assign o_res_err  = res_err;

    // -------------------------------------------------------------------------
    // Command latch, shift count and result capture
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count    <= '0;
            data     <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                data    <= i_cmd_data;
                count   <= len_clamped;
                res_err <= 1'b0;
            end else if (sin_fire) begin
                count <= count - CW'(1);
            end else if (stall_term) begin
                // Remaining shifts are abandoned; the flag rides with this result.
                count   <= '0;
                res_err <= 1'b1;
            end

            // The last shift lands on the edge entering CAPT, so i_sr_q is final here.
            if (state == ST_CAPT) begin
                res_data <= i_sr_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Structural properties
    // -------------------------------------------------------------------------
    a_load_en_excl: assert property (@(posedge i_clk) !(o_sr_load && o_sr_en));

    a_shift_count_live: assert property (@(posedge i_clk) disable iff (i_rst)
        (state == ST_SHIFT) |-> (count != '0));

    a_res_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_res_valid && !i_res_ready) |=>
            (o_res_valid && $stable(o_res_data) && $stable(o_res_err)));

    a_len_bounded: assert property (@(posedge i_clk) disable iff (i_rst)
        count <= CW'(BW_DATA));

endmodule

// File: tb/tb_shift_register_ctrl.sv
module tb_shift_register_ctrl;

    localparam int BW  = 8;
    localparam int TMO = 4;
`ifdef SR_CTRL_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [BW-1:0] cmd_data;
    logic [3:0]    cmd_len;
    logic          sin_valid;
    logic          sin_ready;
    logic          sin_bit;
    logic          sr_load;
    logic          sr_en;
    logic [BW-1:0] sr_d;
    logic          sr_s;
    logic [BW-1:0] sr_q = '0;
    logic          res_valid;
    logic          res_ready;
    logic [BW-1:0] res_data;
    logic          res_err;

    int checks   = 0;
    int failures = 0;
    int n_load   = 0;
    int n_en     = 0;

    always #5 clk = ~clk;

    shift_register_ctrl #(
        .BW_DATA     (BW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_data  (cmd_data),
        .i_cmd_len   (cmd_len),
        .i_sin_valid (sin_valid),
        .o_sin_ready (sin_ready),
        .i_sin_bit   (sin_bit),
        .o_sr_load   (sr_load),
        .o_sr_en     (sr_en),
        .o_sr_d      (sr_d),
        .o_sr_s      (sr_s),
        .i_sr_q      (sr_q),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_data  (res_data),
        .o_res_err   (res_err)
    );

    // Shift register datapath driven by the DUT, plus pulse counters.
    always @(posedge clk) begin
        if (sr_load)    sr_q <= sr_d;
        else if (sr_en) sr_q <= {sr_q[BW-2:0], sr_s};
        if (sr_load) n_load <= n_load + 1;
        if (sr_en)   n_en   <= n_en + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: bits are consumed in accept order, vpat
    // gives i_sin_valid for each SHIFT cycle (all ones past bit 31).
    function automatic void model(input logic [7:0] d, input int k, input logic [15:0] bits,
                                  input logic [31:0] vpat, output logic [7:0] q,
                                  output int nsh, output int lat, output logic err);
        int   cyc;
        int   stall;
        logic v;
        q = d; nsh = 0; err = 1'b0; cyc = 0; stall = 0;
        while (nsh < k && !err) begin
            v = (cyc < 32) ? vpat[cyc] : 1'b1;
            if (v) begin
                q = {q[6:0], bits[nsh]};
                nsh++;
                stall = 0;
            end else begin
                stall++;
                if (TMO_ON && stall == TMO) err = 1'b1;
            end
            cyc++;
        end
        lat = 2 + cyc;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic run_txn(input logic [7:0] data, input logic [3:0] len, input logic [15:0] bits,
                           input logic [31:0] vpat, input int bp);
        int         k, exp_sh, exp_lat, lat, idx, scyc, ld0, en0;
        logic [7:0] exp_q;
        logic       exp_err;
        k = (len > 4'd8) ? 8 : int'(len);
        model(data, k, bits, vpat, exp_q, exp_sh, exp_lat, exp_err);

        check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1; cmd_data = data; cmd_len = len;
        ld0 = n_load; en0 = n_en;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = 8'($urandom); cmd_len = 4'($urandom);
        check_eq("sr_load_pulse", {31'd0, sr_load}, 1);
        check_eq("sr_d_latched", {24'd0, sr_d}, {24'd0, data});

        lat = 0; idx = 0; scyc = 0;
        while (!res_valid && lat < 200) begin
            check_eq("cmd_ready_busy", {31'd0, cmd_ready}, 0);
            if (sin_ready) begin
                sin_valid = (scyc < 32) ? vpat[scyc] : 1'b1;
                sin_bit   = bits[idx];
                if (sin_valid) idx++;
                scyc++;
            end else begin
                sin_valid = 1'($urandom);
                sin_bit   = 1'($urandom);
            end
            #1;
            check_eq("sr_en_gate", {31'd0, sr_en}, {31'd0, sin_ready & sin_valid});
            if (sin_ready) check_eq("sr_s_pass", {31'd0, sr_s}, {31'd0, sin_bit});
            check_eq("load_en_excl", {31'd0, sr_load & sr_en}, 0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        sin_valid = 1'b0;

        check_eq("res_valid", {31'd0, res_valid}, 1);
        check_eq("latency", lat, exp_lat);
        check_eq("sin_ready_cycles", scyc, exp_lat - 2);
        check_eq("load_count", n_load - ld0, 1);
        check_eq("shift_count", n_en - en0, exp_sh);
        check_eq("res_data", {24'd0, res_data}, {24'd0, exp_q});
        check_eq("res_err", {31'd0, res_err}, {31'd0, exp_err});
        if (!res_valid) begin
            do_reset();
            return;
        end

        res_ready = 1'b0;
        repeat (bp) begin
            cmd_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", {31'd0, res_valid}, 1);
            check_eq("hold_data", {24'd0, res_data}, {24'd0, exp_q});
            check_eq("hold_err", {31'd0, res_err}, {31'd0, exp_err});
            check_eq("cmd_ready_resp", {31'd0, cmd_ready}, 0);
            check_eq("sr_d_hold", {24'd0, sr_d}, {24'd0, data});
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("cmd_ready_after", {31'd0, cmd_ready}, 1);
        check_eq("res_valid_after", {31'd0, res_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] vp;
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0;
        sin_valid = 1'b0; sin_bit = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sin_valid = 1'b1;
        #1;
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check_eq("rst_sr_load", {31'd0, sr_load}, 0);
        check_eq("rst_sr_en", {31'd0, sr_en}, 0);
        check_eq("rst_sin_ready", {31'd0, sin_ready}, 0);
        check_eq("rst_res_valid", {31'd0, res_valid}, 0);
        check_eq("rst_sr_d", {24'd0, sr_d}, 0);
        check_eq("rst_res_data", {24'd0, res_data}, 0);
        check_eq("rst_res_err", {31'd0, res_err}, 0);
        sin_valid = 1'b0;

        run_txn(8'hA5, 4'd0,  16'h0000, '1, 0);
        run_txn(8'hA5, 4'd3,  16'b101,  '1, 0);
        run_txn(8'h00, 4'd12, 16'hFFFF, '1, 0);
        run_txn(8'h3C, 4'd4,  16'b0110, {25'h1FFFFFF, 7'b1011001}, 5);

        // Abort mid-SHIFT after 2 of 6 bits.
        cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_len = 4'd6;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("abort_in_shift", {31'd0, sin_ready}, 1);
        sin_valid = 1'b1; sin_bit = 1'b1;
        @(posedge clk); @(negedge clk);
        sin_bit = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_cmd_ready", {31'd0, cmd_ready}, 1);
        check_eq("abort_sr_en", {31'd0, sr_en}, 0);
        check_eq("abort_res_valid", {31'd0, res_valid}, 0);
        check_eq("abort_sin_ready", {31'd0, sin_ready}, 0);
        sin_valid = 1'b0;

`ifdef SR_CTRL_TIMEOUT_EN
        run_txn(8'h81, 4'd5, 16'h0001, 32'h0000_0001, 2);
`endif

        for (int n = 0; n < 40; n++) begin
            vp = ($urandom_range(0, 3) == 0) ? '1 : ($urandom | $urandom);
            run_txn(8'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), vp,
                    int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_register_ctrl.md
Name: shift_register_ctrl

Overview:
Command-driven sequencer for the team's parallel-load/serial-shift register. It accepts a word and shift count over a valid/ready command port, then drives one load cycle. It gates exactly N shift cycles, pulling serial input bits from a valid/ready bit stream. It then captures the register contents and returns them on a valid/ready result port. The block sits between a host/DMA-style requester and the shift_register datapath; the datapath's load, shift-enable, data and serial-in pins are driven only by this block.

Parameters:
BW_DATA, 8, width of the shift register word
TIMEOUT_CYC, 16, stall limit in SHIFT (used only with SR_CTRL_TIMEOUT_EN)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command ready (high only in IDLE)
i_cmd_data  in  BW_DATA  word to load
i_cmd_len  in  CW  shift count; CW = $clog2(BW_DATA+1)
i_sin_valid  in  1  serial bit valid
o_sin_ready  out  1  serial bit accepted (high only in SHIFT)
i_sin_bit  in  1  serial bit
o_sr_load  out  1  to shift register: parallel load
o_sr_en  out  1  to shift register: shift enable
o_sr_d  out  BW_DATA  to shift register: parallel data
o_sr_s  out  1  to shift register: serial in
i_sr_q  in  BW_DATA  from shift register: contents
o_res_valid  out  1  result valid
i_res_ready  in  1  result accepted
o_res_data  out  BW_DATA  captured register word
o_res_err  out  1  timeout flag, qualified by o_res_valid

Behaviour:
- States: IDLE, LOAD, SHIFT, CAPT, RESP. Reset state is IDLE.
- Reset (sync, i_rst=1): state=IDLE, count=0. All outputs are 0 except o_cmd_ready, which is 1 in IDLE. Reset mid-operation aborts at the next edge. Shift-register contents are not cleared.
- IDLE: o_cmd_ready=1. On i_cmd_valid: latch data and len. Len is clamped to BW_DATA if larger. Go to LOAD.
- LOAD: exactly 1 cycle. o_sr_load=1, o_sr_d=latched data, o_sr_en=0. Next state is SHIFT if len>0, else CAPT.
- SHIFT: o_sin_ready=1, o_sr_s=i_sin_bit.
  - o_sr_en = i_sin_valid (combinational).
  - Each accepted bit decrements count.
  - The accept that brings count to 0 moves the FSM to CAPT.
  - No shift occurs while i_sin_valid=0; the FSM waits indefinitely (unless the timeout feature is enabled).
- CAPT: 1 cycle. Register i_sr_q into o_res_data. Go to RESP.
- RESP: o_res_valid=1; o_res_data and o_res_err are held stable. On i_res_ready, go to IDLE.
  - o_cmd_ready stays 0 in RESP. A new command is accepted at the earliest 1 cycle after the result handshake.
- o_sr_load and o_sr_en are never high together. Both are 0 outside LOAD/SHIFT.
- o_sr_d holds the latched data in all states. It resets to 0.
- Latency with len=k and i_sin_valid held high: command accept at edge 0, load at edge 1, shifts at edges 2..k+1, capture at edge k+2. o_res_valid is first high in the cycle after edge k+2.
- Throughput: k+4 cycles per command plus result backpressure.

Optional Feature:
SR_CTRL_TIMEOUT_EN
- Defined:
  - A stall counter counts consecutive SHIFT cycles with i_sin_valid=0; it resets on any accept.
  - When it reaches TIMEOUT_CYC, go to CAPT with the remaining shifts abandoned, and set o_res_err=1 for that result.
  - o_res_err clears on the next command accept.
- Undefined: no stall counter; o_res_err is tied 0; SHIFT waits forever.

Decomposition:
- Shared package/header shift_register_ctrl_pkg holds:
  - state encodings (3-bit localparams for IDLE..RESP);
  - the CW width function/constant;
  - the default TIMEOUT_CYC.
- The FSM and count are in one module. The stall counter is a natural sub-module, sr_stall_cnt (count, clear, terminal flag), instantiated only under SR_CTRL_TIMEOUT_EN.

Test Plan:
- Setup: BW_DATA=8; the bench's shift_register model is q<={q[6:0],s} on en, q<=d on load.
- Cmd 0xA5 len 0 -> one o_sr_load cycle, zero o_sr_en cycles, o_res_data=0xA5, o_res_err=0.
- Cmd 0xA5 len 3, bits 1,0,1 back-to-back -> exactly 3 o_sr_en cycles, o_res_data=0x2D, o_res_valid first high 5 cycles after the accept edge.
- Cmd 0x00 len 12, all bits 1 -> len clamped: 8 shifts, o_sin_ready low after the 8th, o_res_data=0xFF.
- Cmd 0x3C len 4 with i_sin_valid gapped (1,0,0,1,1,0,1) -> 4 shifts only on valid cycles; i_res_ready held low 5 cycles, so o_res_valid and o_res_data stay stable; o_cmd_ready rises 1 cycle after the handshake.
- i_rst pulsed during SHIFT after 2 of 6 bits -> next cycle state=IDLE, o_cmd_ready=1, o_sr_en=0, o_res_valid=0.
- With SR_CTRL_TIMEOUT_EN and TIMEOUT_CYC=4: len 5, 1 bit then valid low -> CAPT after 4 stalled cycles, o_res_err=1.
